// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause field positions,
// exception codes and the MTC0 write masks.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LO  = 8;
  localparam int STATUS_IM_HI  = 15;
  localparam int STATUS_BEV    = 22;

  localparam int CAUSE_EXC_LO  = 2;
  localparam int CAUSE_EXC_HI  = 6;
  localparam int CAUSE_IP_LO   = 8;
  localparam int CAUSE_IP_HW   = 10;
  localparam int CAUSE_IP_HI   = 15;
  localparam int CAUSE_BD      = 31;

  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_RI  = 5'd10,
    EXC_OV  = 5'd12
  } exc_code_t;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // Writable bits come from the new value, everything else is kept.
  function automatic logic [31:0] merge_masked(input logic [31:0] cur,
                                               input logic [31:0] nxt,
                                               input logic [31:0] mask);
    return (cur & ~mask) | (nxt & mask);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: free-running Count (optionally half rate),
// Compare register and the sticky Count==Compare flag.
module cp0_timer #(
  parameter bit COUNT_HALF_RATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic toggle;

  // A Count load restarts the half-rate phase; a Compare load beats a match.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      compare   <= '0;
      toggle    <= 1'b0;
      timer_int <= 1'b0;
    end else begin
      if (count_we) begin
        count  <= wdata;
        toggle <= 1'b0;
      end else begin
        toggle <= ~toggle;
        if (!COUNT_HALF_RATE || toggle)
          count <= count + 32'd1;
      end

      if (compare_we) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if ((count == compare) && ((count != '0) || (compare != '0))) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// MIPS32 CP0 register file (Count, Compare, Status, Cause, EPC, PRId).
// Optional macro CP0_WR_BYPASS_EN forwards same-cycle MTC0 data onto rdata.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID            = 32'h0001_8000,
  parameter bit          COUNT_HALF_RATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_in_delay,
  input  logic        eret,
  input  logic [5:0]  int_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o,
  output logic        int_req_o
);

  logic [31:0] status, cause, epc, count, compare;
  logic [31:0] status_wr_val, cause_wr_val;
  logic        commit_wr;

  // An exception or ERET flushes the MTC0 sharing its cycle.
  assign commit_wr     = we & ~exc_valid & ~eret;
  assign status_wr_val = merge_masked(status, wdata, STATUS_WMASK);
  assign cause_wr_val  = merge_masked(cause, wdata, CAUSE_WMASK);

  cp0_timer #(
    .COUNT_HALF_RATE(COUNT_HALF_RATE)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .count_we  (commit_wr && (waddr == CP0_COUNT)),
    .compare_we(commit_wr && (waddr == CP0_COMPARE)),
    .wdata     (wdata),
    .count     (count),
    .compare   (compare),
    .timer_int (timer_int_o)
  );

  // A nested exception (EXL already set) must not overwrite EPC or BD.
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= STATUS_RESET;
      cause  <= '0;
      epc    <= '0;
    end else begin
      cause[CAUSE_IP_HI:CAUSE_IP_HW] <= {int_i[5] | timer_int_o, int_i[4:0]};
      if (exc_valid) begin
        status[STATUS_EXL]              <= 1'b1;
        cause[CAUSE_EXC_HI:CAUSE_EXC_LO] <= exc_code;
        if (!status[STATUS_EXL]) begin
          epc             <= exc_in_delay ? (exc_pc - 32'd4) : exc_pc;
          cause[CAUSE_BD] <= exc_in_delay;
        end
      end else if (eret) begin
        status[STATUS_EXL] <= 1'b0;
      end else if (we) begin
        case (waddr)
          CP0_STATUS: status <= status_wr_val;
          CP0_CAUSE:  cause[CAUSE_IP_HW-1:CAUSE_IP_LO] <= cause_wr_val[CAUSE_IP_HW-1:CAUSE_IP_LO];
          CP0_EPC:    epc <= wdata;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    logic [31:0] count_v, compare_v, status_v, cause_v, epc_v;
    count_v   = count;
    compare_v = compare;
    status_v  = status;
    cause_v   = cause;
    epc_v     = epc;
`ifdef CP0_WR_BYPASS_EN
    if (commit_wr && (waddr == raddr)) begin
      case (waddr)
        CP0_COUNT:   count_v   = wdata;
        CP0_COMPARE: compare_v = wdata;
        CP0_STATUS:  status_v  = status_wr_val;
        CP0_CAUSE:   cause_v   = cause_wr_val;
        CP0_EPC:     epc_v     = wdata;
        default:     ;
      endcase
    end
`endif
    case (raddr)
      CP0_COUNT:   rdata = count_v;
      CP0_COMPARE: rdata = compare_v;
      CP0_STATUS:  rdata = status_v;
      CP0_CAUSE:   rdata = cause_v;
      CP0_EPC:     rdata = epc_v;
      CP0_PRID:    rdata = PRID;
      default:     rdata = '0;
    endcase
  end

  assign status_o  = status;
  assign cause_o   = cause;
  assign epc_o     = epc;
  assign int_req_o = status[STATUS_IE] & ~status[STATUS_EXL] &
                     (|(status[STATUS_IM_HI:STATUS_IM_LO] & cause[CAUSE_IP_HI:CAUSE_IP_LO]));

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: table-driven MTC0/MFC0 vectors plus
// hand-written exception, timer, bypass and reset sequences.
module tb_cp0_regfile;

  localparam logic [31:0] PRID_VAL = 32'h0001_8000;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_delay;
  logic        eret;
  logic [5:0]  int_i;
  logic [31:0] status_o, cause_o, epc_o;
  logic        timer_int_o, int_req_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp_rdata;
    logic        exp_int_req;
  } vec_t;

  vec_t vecs[26];

  cp0_regfile #(
    .PRID(PRID_VAL),
    .COUNT_HALF_RATE(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .raddr       (raddr),
    .rdata       (rdata),
    .exc_valid   (exc_valid),
    .exc_code    (exc_code),
    .exc_pc      (exc_pc),
    .exc_in_delay(exc_in_delay),
    .eret        (eret),
    .int_i       (int_i),
    .status_o    (status_o),
    .cause_o     (cause_o),
    .epc_o       (epc_o),
    .timer_int_o (timer_int_o),
    .int_req_o   (int_req_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra, input logic [31:0] er, input logic ei);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.exp_rdata = er; v.exp_int_req = ei;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra);
    we = w; waddr = wa; wdata = wd; raddr = ra;
    #1;
  endtask

  task automatic setExc(input logic v, input logic [4:0] code, input logic [31:0] pc,
                        input logic dly, input logic er);
    exc_valid = v; exc_code = code; exc_pc = pc; exc_in_delay = dly; eret = er;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  initial begin
    vecs[0]  = mk(0, 0,  32'h0,         9,  32'h0,         0);
    vecs[1]  = mk(0, 0,  32'h0,         11, 32'h0,         0);
    vecs[2]  = mk(0, 0,  32'h0,         12, 32'h0040_0000, 0);
    vecs[3]  = mk(0, 0,  32'h0,         13, 32'h0,         0);
    vecs[4]  = mk(0, 0,  32'h0,         14, 32'h0,         0);
    vecs[5]  = mk(0, 0,  32'h0,         15, PRID_VAL,      0);
    vecs[6]  = mk(0, 0,  32'h0,         0,  32'h0,         0);
    vecs[7]  = mk(1, 12, 32'hFFFF_FFFF, 13, 32'h0,         0);
    vecs[8]  = mk(0, 0,  32'h0,         12, 32'h0040_FF03, 0);
    vecs[9]  = mk(1, 12, 32'h0000_FF01, 12, 32'h0040_FF03, 0);
    vecs[10] = mk(1, 13, 32'hFFFF_FFFF, 12, 32'h0040_FF01, 0);
    vecs[11] = mk(0, 0,  32'h0,         13, 32'h0000_0300, 1);
    vecs[12] = mk(1, 13, 32'h0,         13, 32'h0000_0300, 1);
    vecs[13] = mk(0, 0,  32'h0,         13, 32'h0,         0);
    vecs[14] = mk(1, 5,  32'hFFFF_FFFF, 5,  32'h0,         0);
    vecs[15] = mk(0, 0,  32'h0,         5,  32'h0,         0);
    vecs[16] = mk(1, 15, 32'h0,         14, 32'h0,         0);
    vecs[17] = mk(0, 0,  32'h0,         15, PRID_VAL,      0);
    vecs[18] = mk(1, 14, 32'h0000_1234, 11, 32'h0,         0);
    vecs[19] = mk(0, 0,  32'h0,         14, 32'h0000_1234, 0);
    vecs[20] = mk(1, 14, 32'h0,         13, 32'h0,         0);
    vecs[21] = mk(0, 0,  32'h0,         14, 32'h0,         0);
    vecs[22] = mk(1, 12, 32'h0,         14, 32'h0,         0);
    vecs[23] = mk(0, 0,  32'h0,         12, 32'h0040_0000, 0);
    vecs[24] = mk(1, 12, 32'h0000_FF01, 11, 32'h0,         0);
    vecs[25] = mk(0, 0,  32'h0,         12, 32'h0040_FF01, 0);

    rst = 1'b1; we = 0; waddr = 0; wdata = 0; raddr = 0; int_i = 0;
    setExc(0, 0, 0, 0, 0);
    tick;
    tick;
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr);
      checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_int_req", i), {31'b0, int_req_o}, {31'b0, vecs[i].exp_int_req});
      tick;
    end
    applyStimulus(0, 0, 0, 13);

    // Hardware interrupt sampled with one cycle of latency.
    int_i = 6'b000100;
    #1;
    checkOutput("ip12_before_edge", cause_o, 32'h0);
    tick;
    checkOutput("ip12_cause", rdata, 32'h0000_1000);
    checkOutput("ip12_int_req", {31'b0, int_req_o}, 32'h1);
    int_i = 6'b0;
    tick;
    checkOutput("ip12_clear", cause_o, 32'h0);
    checkOutput("ip12_clear_req", {31'b0, int_req_o}, 32'h0);

    // Exceptions, nesting, ERET and flush interactions.
    setExc(1, 5'd8, 32'h8000_0104, 1, 0);
    tick;
    setExc(0, 0, 0, 0, 0);
    checkOutput("exc1_epc", epc_o, 32'h8000_0100);
    checkOutput("exc1_cause", cause_o, 32'h8000_0020);
    checkOutput("exc1_status", status_o, 32'h0040_FF03);
    setExc(1, 5'd12, 32'h0000_0200, 0, 0);
    tick;
    setExc(0, 0, 0, 0, 0);
    checkOutput("exc2_epc", epc_o, 32'h8000_0100);
    checkOutput("exc2_cause", cause_o, 32'h8000_0030);
    setExc(1, 5'd10, 32'h0, 0, 1);
    tick;
    setExc(0, 0, 0, 0, 0);
    checkOutput("exc_eret_status", status_o, 32'h0040_FF03);
    checkOutput("exc_eret_cause", cause_o, 32'h8000_0028);
    setExc(0, 0, 0, 0, 1);
    tick;
    setExc(0, 0, 0, 0, 0);
    checkOutput("eret_status", status_o, 32'h0040_FF01);
    checkOutput("eret_epc", epc_o, 32'h8000_0100);
    setExc(1, 5'd0, 32'h0000_0300, 0, 0);
    applyStimulus(1, 12, 32'h0, 12);
    tick;
    setExc(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 12);
    checkOutput("exc_we_status", status_o, 32'h0040_FF03);
    checkOutput("exc_we_epc", epc_o, 32'h0000_0300);
    checkOutput("exc_we_cause", cause_o, 32'h0);
    setExc(0, 0, 0, 0, 1);
    applyStimulus(1, 12, 32'h0, 12);
    tick;
    setExc(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 12);
    checkOutput("eret_we_status", status_o, 32'h0040_FF01);

    // Count wrap at half rate.
    applyStimulus(1, 9, 32'hFFFF_FFFE, 9);
    tick;
    applyStimulus(0, 0, 0, 9);
    checkOutput("count_load", rdata, 32'hFFFF_FFFE);
    tick;
    checkOutput("count_hold", rdata, 32'hFFFF_FFFE);
    tick;
    checkOutput("count_ffff", rdata, 32'hFFFF_FFFF);
    tick;
    checkOutput("count_ffff_hold", rdata, 32'hFFFF_FFFF);
    tick;
    checkOutput("count_wrap", rdata, 32'h0);

    // Compare match, sticky flag, write-wins clear.
    applyStimulus(1, 11, 32'd5, 11);
    tick;
    applyStimulus(0, 0, 0, 11);
    checkOutput("compare_read", rdata, 32'd5);
    checkOutput("timer_idle", {31'b0, timer_int_o}, 32'h0);
    applyStimulus(0, 0, 0, 9);
    begin
      int n;
      n = 0;
      while (rdata != 32'd5 && n < 100) begin
        tick;
        n++;
      end
      if (n >= 100) begin
        checks++;
        errors++;
        $display("[TB] FAIL count_reach5: got %h, expected %h", rdata, 32'd5);
      end
    end
    checkOutput("timer_at_match", {31'b0, timer_int_o}, 32'h0);
    tick;
    checkOutput("timer_set", {31'b0, timer_int_o}, 32'h1);
    checkOutput("timer_ip_latency", cause_o, 32'h0);
    applyStimulus(1, 11, 32'd100, 9);
    tick;
    applyStimulus(0, 0, 0, 9);
    checkOutput("timer_cleared", {31'b0, timer_int_o}, 32'h0);
    checkOutput("timer_ip15", cause_o, 32'h0000_8000);
    checkOutput("timer_int_req", {31'b0, int_req_o}, 32'h1);
    tick;
    checkOutput("timer_ip15_clear", cause_o, 32'h0);

    // Same-cycle MTC0/MFC0 on EPC.
    applyStimulus(1, 14, 32'h0000_1234, 14);
`ifdef CP0_WR_BYPASS_EN
    checkOutput("bypass_rdata", rdata, 32'h0000_1234);
`else
    checkOutput("bypass_rdata", rdata, 32'h0000_0300);
`endif
    tick;
    applyStimulus(0, 0, 0, 14);
    checkOutput("epc_written", rdata, 32'h0000_1234);

    // Reset mid-operation overrides every other input.
    rst = 1'b1;
    int_i = 6'h3F;
    setExc(1, 5'd12, 32'h0000_0800, 1, 0);
    applyStimulus(1, 12, 32'hFFFF_FFFF, 9);
    tick;
    rst = 1'b0;
    int_i = 6'h0;
    setExc(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 9);
    checkOutput("rst_count", rdata, 32'h0);
    checkOutput("rst_status", status_o, 32'h0040_0000);
    checkOutput("rst_cause", cause_o, 32'h0);
    checkOutput("rst_epc", epc_o, 32'h0);
    checkOutput("rst_timer", {31'b0, timer_int_o}, 32'h0);
    applyStimulus(0, 0, 0, 11);
    checkOutput("rst_compare", rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- MIPS32 Coprocessor-0 register file: holds Count, Compare, Status, Cause, EPC and PRId.
- Services MTC0 writes and MFC0 reads from the pipeline.
- Records exception and ERET commits from the exception controller.
- Feeds Status/Cause/EPC and the combined interrupt request back to that controller. Sits beside the MEM/WB stage.

Parameters:
- PRID, 32'h0001_8000, read-only value of PRId (reg 15).
- COUNT_HALF_RATE, 1, 1 = Count increments every 2nd clock; 0 = every clock.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- we  in  1  MTC0 write strobe.
- waddr  in  5  MTC0 destination register number.
- wdata  in  32  MTC0 data.
- raddr  in  5  MFC0 source register number.
- rdata  out  32  MFC0 data, combinational.
- exc_valid  in  1  exception committed this cycle.
- exc_code  in  5  Cause.ExcCode value (0 Int, 8 Sys, 10 RI, 12 Ov).
- exc_pc  in  32  PC of the faulting instruction.
- exc_in_delay  in  1  faulting instruction is in a branch delay slot.
- eret  in  1  ERET committed this cycle.
- int_i  in  6  hardware interrupt lines HW5..HW0, level-sensitive.
- status_o  out  32  Status register.
- cause_o  out  32  Cause register.
- epc_o  out  32  EPC register.
- timer_int_o  out  1  Count==Compare pending flag.
- int_req_o  out  1  interrupt request to the exception controller.

Behaviour:
- Reset values:
  - Count=0, Compare=0, Cause=0, EPC=0, timer_int_o=0, internal count toggle=0.
  - Status=32'h0040_0000: BEV bit22 reads 1 and is read-only.
  - int_req_o=0 follows from these values.
- Register map: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId. All other addresses read 0 and ignore writes.
- Status write mask: IM[15:8], EXL[1], IE[0]. All other bits keep reset value.
- Cause:
  - Only IP[9:8] (software interrupts) are writable.
  - IP[15:10] is sampled every clock as {int_i[5] | timer_int_o, int_i[4:0]}; one-cycle latency from int_i.
  - BD[31] and ExcCode[6:2] are written only by exceptions.
- Count:
  - Free-running; with COUNT_HALF_RATE=1 it increments on cycles where the toggle is 1, and the toggle flips every clock.
  - Wraps 32'hFFFF_FFFF -> 0 with no flag.
  - An MTC0 to Count loads wdata and clears the toggle; that cycle has no increment.
- Compare: an MTC0 to Compare loads wdata and clears timer_int_o in the same edge.
- Timer flag: timer_int_o sets on the edge after Count==Compare (Count != 0 or Compare != 0). It holds until a Compare write.
- Exception (exc_valid=1) at the clock edge:
  - Status.EXL <= 1; Cause.ExcCode <= exc_code.
  - If Status.EXL was 0: EPC <= exc_in_delay ? exc_pc-4 : exc_pc, and Cause.BD <= exc_in_delay.
  - If Status.EXL was already 1, EPC and BD are unchanged.
- ERET: Status.EXL <= 0 at the clock edge.
- Simultaneous events:
  - exc_valid and eret together: the exception wins and eret is ignored.
  - exc_valid or eret together with we: the MTC0 is discarded (the instruction is flushed). Count and timer still advance.
  - A Compare match in the same cycle as a Compare write: the write wins and the flag is cleared.
- int_req_o = Status.IE & ~Status.EXL & |(Status.IM[15:8] & Cause.IP[15:8]). Combinational from registers.
- rdata is combinational from the current register values, subject to the optional feature below.
- Reset asserted mid-operation returns every register to its reset value on that edge, regardless of other inputs.

Optional Feature:
- CP0_WR_BYPASS_EN.
- Defined: when we=1, exc_valid=0, eret=0 and waddr==raddr, rdata returns the masked value that will be written. For Count and Compare this is wdata; for Status/Cause it is the merge of write-mask bits from wdata with the current values of the other bits.
- Undefined: rdata always shows the pre-edge register value.

Decomposition:
- Shared package cp0_pkg:
  - register number constants (CP0_COUNT=9 … CP0_PRID=15);
  - Status/Cause bit positions (EXL, IE, IM range, IP range, BD, ExcCode range);
  - ExcCode constants;
  - Status/Cause write masks.
- One sub-module, cp0_timer: holds Count, Compare, the toggle and timer_int_o, with write-port inputs.

Test Plan:
- Reset, then read regs 9/11/12/13/14/15 -> 0, 0, 32'h0040_0000, 0, 0, PRID.
- MTC0 Status=32'hFFFF_FFFF -> read 32'h0040_FF03. int_i[2]=1 -> the following cycle Cause.IP12=1 and int_req_o=1.
- exc_valid, exc_code=8, exc_pc=32'h8000_0104, exc_in_delay=1 -> EPC=32'h8000_0100, Cause=32'h8000_0020, EXL=1. A second exception with exc_pc=32'h200 -> EPC unchanged. eret -> EXL=0.
- MTC0 Count=32'hFFFF_FFFE, COUNT_HALF_RATE=1 -> Count is 0 four clocks later. MTC0 Compare=5 -> timer_int_o rises one edge after Count reaches 5; a Compare write clears it.
- exc_valid and we (Status=0) in the same cycle -> Status.IE unchanged, EXL=1.
- With CP0_WR_BYPASS_EN: we to EPC = 32'h1234 with raddr=14 -> rdata=32'h1234 in the same cycle. Without the macro -> the old EPC value.
